// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 5-stage pipeline sequencer.
//   state_e      sequencer state (RUN = normal flow, MWAIT = memory wait stall)
//   REG_W        register-index width
//   STAGE_F..W   stage indices used to address keep/dirty vectors
package pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_e;

    localparam int unsigned REG_W = 3;

    localparam int unsigned STAGE_F = 0;
    localparam int unsigned STAGE_D = 1;
    localparam int unsigned STAGE_E = 2;
    localparam int unsigned STAGE_M = 3;
    localparam int unsigned STAGE_W = 4;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   rsrc1, rsrc2  source registers of the instruction in D
//   use1, use2    D instruction actually reads the matching source
//   load          E instruction is a load
//   rdst          destination register of the E instruction
//   lu            D needs the value the E load has not produced yet
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rsrc1,
    input  logic [REG_W-1:0] rsrc2,
    input  logic             use1,
    input  logic             use2,
    input  logic             load,
    input  logic [REG_W-1:0] rdst,
    output logic             lu
);

    assign lu = load & ((use1 & (rsrc1 == rdst)) | (use2 & (rsrc2 == rdst)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the F/D/E/M/W pipeline.
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   d_rsrc1/2, d_use1/2       operands of the D instruction
//   e_load, e_rdst            E instruction is a load, and its destination
//   jump                      taken branch resolved in E
//   m_mem                     M instruction accesses data memory
//   keepF..keepW              hold the corresponding pipeline register (combinational)
//   dirtyD..dirtyW            stage holds a bubble (registered)
//   stall_cnt                 saturating count of cycles with keepF = 1
// Priority: memory wait stall > branch flush > load-use bubble.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] d_rsrc1,
    input  logic [REG_W-1:0] d_rsrc2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             e_load,
    input  logic [REG_W-1:0] e_rdst,
    input  logic             jump,
    input  logic             m_mem,
    output logic             keepF,
    output logic             keepD,
    output logic             keepE,
    output logic             keepM,
    output logic             keepW,
    output logic             dirtyD,
    output logic             dirtyE,
    output logic             dirtyM,
    output logic             dirtyW,
    output logic [CNT_W-1:0] stall_cnt
);

    // The wait counter holds the stall cycles still owed after the entry cycle.
    localparam int unsigned WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    state_e                       state_q, state_d;
    logic [WAIT_W-1:0]            wait_q, wait_d;
    logic                         done_q, done_d;
    logic [STAGE_W:STAGE_D]       dirty_q, dirty_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
    logic [STAGE_W:STAGE_F]       keep;
    logic                         lu, lu_ok, jump_ok, mem_ok;

    hazard_detect u_hazard_detect (
        .rsrc1 (d_rsrc1),
        .rsrc2 (d_rsrc2),
        .use1  (d_use1),
        .use2  (d_use2),
        .load  (e_load),
        .rdst  (e_rdst),
        .lu    (lu)
    );

    always_comb begin
        // Inputs only count when they come from a real (non-bubble) instruction; done_q
        // stops an already-served M access from starting a second wait.
        lu_ok   = lu & ~dirty_q[STAGE_E] & ~dirty_q[STAGE_D];
        jump_ok = jump & ~dirty_q[STAGE_E];
        mem_ok  = m_mem & ~dirty_q[STAGE_M] & ~done_q & (MEM_WAIT > 0);

        state_d = state_q;
        wait_d  = wait_q;
        done_d  = done_q;
        keep    = '0;
        // Default: everything advances and a fresh instruction enters D.
        dirty_d = {dirty_q[STAGE_M], dirty_q[STAGE_E], dirty_q[STAGE_D], 1'b0};

        unique case (state_q)
            RUN: begin
                if (mem_ok) begin
                    keep    = '1;
                    dirty_d = dirty_q;
                    wait_d  = WAIT_W'(MEM_WAIT - 1);
                    if (MEM_WAIT > 1) begin
                        state_d = MWAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (jump_ok) begin
                    // Kill D and E; the branch itself moves on into M.
                    dirty_d[STAGE_D] = 1'b1;
                    dirty_d[STAGE_E] = 1'b1;
                end else if (lu_ok) begin
                    keep[STAGE_F]    = 1'b1;
                    keep[STAGE_D]    = 1'b1;
                    dirty_d[STAGE_D] = dirty_q[STAGE_D];
                    dirty_d[STAGE_E] = 1'b1;
                end
            end
            MWAIT: begin
                keep    = '1;
                dirty_d = dirty_q;
                wait_d  = wait_q - 1'b1;
                if (wait_q == WAIT_W'(1)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // A new instruction reaches M whenever M is not held.
        if (!keep[STAGE_M]) begin
            done_d = 1'b0;
        end

        stall_cnt_d = (keep[STAGE_F] && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            done_q      <= 1'b0;
            dirty_q     <= '1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            done_q      <= done_d;
            dirty_q     <= dirty_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign keepF     = keep[STAGE_F];
    assign keepD     = keep[STAGE_D];
    assign keepE     = keep[STAGE_E];
    assign keepM     = keep[STAGE_M];
    assign keepW     = keep[STAGE_W];
    assign dirtyD    = dirty_q[STAGE_D];
    assign dirtyE    = dirty_q[STAGE_E];
    assign dirtyM    = dirty_q[STAGE_M];
    assign dirtyW    = dirty_q[STAGE_W];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: three sequencers (MEM_WAIT = 2 / 0 / 1, the last with a 4-bit counter) share
// one stimulus stream. Each cycle a reference model predicts every instance's outputs and
// pushes them to a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0] dut;
        logic [4:0]  keep;   // {W, M, E, D, F}
        logic [3:0]  dirty;  // {W, M, E, D}
        logic [31:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] d_rsrc1, d_rsrc2, e_rdst;
    logic       d_use1, d_use2, e_load, jump, m_mem;

    logic [4:0]  keep_o  [NDUT];
    logic [3:0]  dirty_o [NDUT];
    logic [31:0] cnt_o   [NDUT];

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: valid bit per stage {W, M, E, D}, remaining full-stall
    // cycles, whether the current M access was already served, stall total.
    logic [3:0] vld       [NDUT];
    int         hold_left [NDUT];
    bit         served    [NDUT];
    int         stalls    [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned MW = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
        localparam int unsigned CW = (g == 2) ? 4 : 16;
        logic          kf, kd, ke, km, kw, dd, de, dm, dw;
        logic [CW-1:0] cnt;

        pipe_ctrl #(.MEM_WAIT(MW), .CNT_W(CW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .d_rsrc1   (d_rsrc1),
            .d_rsrc2   (d_rsrc2),
            .d_use1    (d_use1),
            .d_use2    (d_use2),
            .e_load    (e_load),
            .e_rdst    (e_rdst),
            .jump      (jump),
            .m_mem     (m_mem),
            .keepF     (kf),
            .keepD     (kd),
            .keepE     (ke),
            .keepM     (km),
            .keepW     (kw),
            .dirtyD    (dd),
            .dirtyE    (de),
            .dirtyM    (dm),
            .dirtyW    (dw),
            .stall_cnt (cnt)
        );

        assign keep_o[g]  = {kw, km, ke, kd, kf};
        assign dirty_o[g] = {dw, dm, de, dd};
        assign cnt_o[g]   = 32'(cnt);
    end

    function automatic int mem_wait_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
    endfunction

    function automatic int cnt_max_of(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    // Predict this cycle's outputs for instance k from the current inputs, then advance.
    task automatic model_cycle(input int k, output exp_t e);
        bit lu;
        e.dut = k;
        if (!rst) begin
            vld[k]       = 4'b0000;
            hold_left[k] = 0;
            served[k]    = 1'b0;
            stalls[k]    = 0;
            e.keep       = 5'b00000;
            e.dirty      = 4'b1111;
            e.cnt        = 0;
        end else begin
            e.dirty = ~vld[k];
            e.cnt   = stalls[k];
            lu = e_load && ((d_use1 && d_rsrc1 == e_rdst) || (d_use2 && d_rsrc2 == e_rdst));
            if (hold_left[k] == 0 && mem_wait_of(k) > 0 && m_mem && vld[k][2] && !served[k])
                hold_left[k] = mem_wait_of(k);
            if (hold_left[k] > 0) begin
                e.keep = 5'b11111;
                hold_left[k]--;
                if (hold_left[k] == 0) served[k] = 1'b1;
            end else if (jump && vld[k][1]) begin
                e.keep = 5'b00000;
                vld[k] = {vld[k][2], vld[k][1], 2'b00};
            end else if (lu && vld[k][1] && vld[k][0]) begin
                e.keep = 5'b00011;
                vld[k] = {vld[k][2], vld[k][1], 1'b0, vld[k][0]};
            end else begin
                e.keep = 5'b00000;
                vld[k] = {vld[k][2:0], 1'b1};
            end
            if (!e.keep[3]) served[k] = 1'b0;
            if (e.keep[0] && stalls[k] < cnt_max_of(k)) stalls[k]++;
        end
    endtask

    task automatic check(input string name, input int k, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: actual %0h required %0h", name, k, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs (between edges), queue predictions, wait for the next edge.
    task automatic cyc(input logic r, input logic jm, input logic mm, input logic el,
                       input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2);
        exp_t e;
        rst = r; jump = jm; m_mem = mm; e_load = el; e_rdst = rd;
        d_rsrc1 = s1; d_rsrc2 = s2; d_use1 = u1; d_use2 = u2;
        for (int k = 0; k < NDUT; k++) begin
            model_cycle(k, e);
            sbq.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("keep",      e.dut, 32'(keep_o[e.dut]),  32'(e.keep));
                check("dirty",     e.dut, 32'(dirty_o[e.dut]), 32'(e.dirty));
                check("stall_cnt", e.dut, cnt_o[e.dut],        e.cnt);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; jump = 0; m_mem = 0; e_load = 0; e_rdst = 0;
        d_rsrc1 = 0; d_rsrc2 = 0; d_use1 = 0; d_use2 = 0;
        @(posedge clk);
        #2;
        // Reset and fill
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // Load-use, then the same without the operand read
        cyc(1, 0, 0, 1, 3, 3, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 1, 3, 3, 0, 0, 0);
        idle(2);
        // Taken branch, then a branch whose E stage is already a bubble
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Memory access held high: wait, one advance, no re-trigger on the same access
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Collision of memory wait, branch and load-use
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 5, 5, 5, 1, 1);
        idle(4);
        // Reset dropped in the middle of a wait
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        // Long stream of load-use hazards to saturate the narrow counter
        for (int i = 0; i < 44; i++) cyc(1, 0, 0, 1, 2, 2, 6, 1, 0);
        idle(3);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 40),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                3'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);
        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
